serdesphy_pdn_seq: RTL and testbench
====================================

Name: serdesphy_pdn_seq

Overview:
Power-down/wake sequencer. It is the shutdown-direction counterpart of the PHY power-on-reset controller.
- On CSR power-down request or supply loss, it quiesces the datapath, then applies analog isolation, analog reset and digital reset, in that order. On wake, it releases them in reverse order.
- Its iso/reset outputs are override terms, ANDed downstream with the POR controller's outputs. 1 = no override.

Parameters:
- ISO_TIME, 15: isolation settle count; state lasts ISO_TIME+1 cycles.
- RST_TIME, 10: reset hold count per reset step; each state lasts RST_TIME+1 cycles.
- QUIESCE_TIMEOUT, 64: maximum cycles to wait for quiesce_ack. Used only with SERDESPHY_PDN_TIMEOUT_EN.

Ports:
- clk  in  1  reference clock, 24 MHz
- rst_n_in  in  1  asynchronous active-low reset
- dvdd_ok  in  1  1.8V supply OK
- avdd_ok  in  1  3.3V supply OK
- por_complete  in  1  POR sequence complete
- pdn_req  in  1  level power-down request from CSR
- quiesce_ack  in  1  datapath idle acknowledge
- fault_clr  in  1  single-cycle pulse; clears pdn_fault
- quiesce_req  out  1  request datapath to go idle
- analog_iso_n  out  1  isolation override, active-low
- analog_reset_n  out  1  analog reset override, active-low
- digital_reset_n  out  1  digital reset override, active-low
- pdn_active  out  1  sequence in progress (down or wake)
- pdn_done  out  1  block fully powered down
- pdn_fault  out  1  sticky: emergency shutdown or quiesce timeout

Behaviour:
- Clock, reset and timing:
  - One clock, clk.
  - Reset rst_n_in is asynchronous, active-low.
  - All outputs are registered and take their new value on the cycle a state is entered.
  - 16-bit timer: loaded on state entry, decremented each cycle, state exits when it reads 0.
- Reset values: state WAIT_POR; quiesce_req=0, analog_iso_n=1, analog_reset_n=1, digital_reset_n=1, pdn_active=0, pdn_done=0, pdn_fault=0, timer=0.
- supplies_ok = dvdd_ok & avdd_ok.
- States:
  - WAIT_POR: no overrides. por_complete=1 -> ACTIVE.
  - ACTIVE: if !supplies_ok -> EMERG. Else if pdn_req -> QUIESCE; quiesce_req=1 and pdn_active=1 from the next cycle.
  - QUIESCE: pdn_req=0 before ack -> ACTIVE (abort; quiesce_req=0, pdn_active=0). quiesce_ack=1 -> ISO.
  - ISO: analog_iso_n=0, load ISO_TIME; on expiry -> ARST.
  - ARST: analog_reset_n=0, load RST_TIME; on expiry -> DRST.
  - DRST: digital_reset_n=0, load RST_TIME; on expiry -> OFF.
  - OFF: pdn_done=1, pdn_active=0, quiesce_req held 1, all overrides held.
    - por_complete=0 -> WAIT_POR, releasing all overrides in one cycle (POR owns re-sequencing).
    - Else pdn_req=0 with supplies_ok -> WAKE_D.
  - WAKE_D: pdn_done=0, pdn_active=1, digital_reset_n=1, quiesce_req=0, load RST_TIME; on expiry -> WAKE_A.
  - WAKE_A: analog_reset_n=1, load ISO_TIME; on expiry -> WAKE_ISO.
  - WAKE_ISO: analog_iso_n=1; next cycle -> ACTIVE with pdn_active=0.
  - EMERG: single cycle. All three overrides=0 simultaneously, quiesce_req=0, pdn_fault=1; -> OFF.
- Supply loss: !supplies_ok in QUIESCE, ISO, ARST, DRST, WAKE_D, WAKE_A or WAKE_ISO -> EMERG next cycle, remaining timers skipped. Supply loss in OFF: stay in OFF; wake is blocked until supplies_ok=1.
- Simultaneous events:
  - supplies_ok=0 with pdn_req=1 in ACTIVE: EMERG wins.
  - fault_clr in the same cycle as a fault set: set wins.
- pdn_req toggling after ISO entry is ignored until OFF is reached.
- Wake from OFF does not clear pdn_fault; only fault_clr or reset clears it.
- Undefined state encoding -> EMERG.
- rst_n_in asserted mid-sequence: immediate return to reset values. The POR controller guarantees safety during reset.

Optional Feature:
SERDESPHY_PDN_TIMEOUT_EN
- Defined: QUIESCE loads QUIESCE_TIMEOUT on entry. If the count expires without quiesce_ack, set pdn_fault=1 and proceed to ISO.
- Undefined: QUIESCE waits indefinitely for ack or abort; pdn_fault is set only by EMERG.

Test Plan:
- Normal shutdown (defaults). por_complete=1, supplies ok, pdn_req at cycle 0, quiesce_ack at cycle 5:
  - quiesce_req=1 at cycle 1
  - analog_iso_n=0 at 6, analog_reset_n=0 at 22, digital_reset_n=0 at 33
  - pdn_done=1 and pdn_active=0 at 44
- Wake. From OFF, drop pdn_req at cycle 0:
  - digital_reset_n=1 and pdn_done=0 at 1
  - analog_reset_n=1 at 12, analog_iso_n=1 at 28, pdn_active=0 at 29
- Emergency. avdd_ok=0 during ARST:
  - next cycle all overrides 0, pdn_fault=1
  - following cycle OFF, pdn_done=1
  - fault_clr pulse clears pdn_fault.
- Abort. pdn_req high 3 cycles, low before quiesce_ack: quiesce_req returns 0, state ACTIVE, no override ever asserted.
- Timeout. With SERDESPHY_PDN_TIMEOUT_EN, quiesce_ack held 0: pdn_fault=1 and analog_iso_n=0 at cycle 66 after request. Without the macro, still waiting at cycle 1000.
- Async reset at cycle 25 of shutdown: all outputs at reset values immediately, independent of clk; state WAIT_POR.

Source files
------------

// File: rtl/serdesphy_pdn_seq_if.sv
// Handshake/status bundle for serdesphy_pdn_seq.
// slave: the sequencer side. master: the CSR/datapath/supervisor side.
interface serdesphy_pdn_seq_if;
    logic dvdd_ok;
    logic avdd_ok;
    logic por_complete;
    logic pdn_req;
    logic quiesce_ack;
    logic fault_clr;
    logic quiesce_req;
    logic analog_iso_n;
    logic analog_reset_n;
    logic digital_reset_n;
    logic pdn_active;
    logic pdn_done;
    logic pdn_fault;

    modport slave (
        input  dvdd_ok, avdd_ok, por_complete, pdn_req, quiesce_ack, fault_clr,
        output quiesce_req, analog_iso_n, analog_reset_n, digital_reset_n,
               pdn_active, pdn_done, pdn_fault
    );

    modport master (
        output dvdd_ok, avdd_ok, por_complete, pdn_req, quiesce_ack, fault_clr,
        input  quiesce_req, analog_iso_n, analog_reset_n, digital_reset_n,
               pdn_active, pdn_done, pdn_fault
    );
endinterface

// File: rtl/serdesphy_pdn_seq.sv
// Power-down/wake sequencer. Shutdown order: quiesce, analog isolation,
// analog reset, digital reset; wake releases them in reverse order.
// Iso/reset outputs are override terms (1 = no override), ANDed downstream
// with the POR controller outputs.
// Optional macro SERDESPHY_PDN_TIMEOUT_EN: bounds the quiesce wait to
// QUIESCE_TIMEOUT cycles, then flags pdn_fault and proceeds to isolation.
module serdesphy_pdn_seq #(
    parameter int unsigned ISO_TIME        = 15,
    parameter int unsigned RST_TIME        = 10,
    parameter int unsigned QUIESCE_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n_in,
    serdesphy_pdn_seq_if.slave   bus
);

    typedef enum logic [3:0] {
        WAIT_POR = 4'd0,
        ACTIVE   = 4'd1,
        QUIESCE  = 4'd2,
        ISO      = 4'd3,
        ARST     = 4'd4,
        DRST     = 4'd5,
        OFF      = 4'd6,
        WAKE_D   = 4'd7,
        WAKE_A   = 4'd8,
        WAKE_ISO = 4'd9,
        EMERG    = 4'd10
    } state_t;

    localparam logic [15:0] ISO_LD = 16'(ISO_TIME);
    localparam logic [15:0] RST_LD = 16'(RST_TIME);
    localparam logic [15:0] QTO_LD = 16'(QUIESCE_TIMEOUT);

    state_t      state, state_nxt;
    logic [15:0] timer, timer_nxt;
    logic        timeout_fault;
    logic        supplies_ok;

    logic q_r, iso_r, ar_r, dr_r, act_r, done_r, fault_r;
    logic q_nxt, iso_nxt, ar_nxt, dr_nxt, act_nxt, done_nxt, fault_nxt;

    assign supplies_ok = bus.dvdd_ok & bus.avdd_ok;

    // State, timer and registered outputs.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= WAIT_POR;
            timer   <= '0;
            q_r     <= 1'b0;
            iso_r   <= 1'b1;
            ar_r    <= 1'b1;
            dr_r    <= 1'b1;
            act_r   <= 1'b0;
            done_r  <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            q_r     <= q_nxt;
            iso_r   <= iso_nxt;
            ar_r    <= ar_nxt;
            dr_r    <= dr_nxt;
            act_r   <= act_nxt;
            done_r  <= done_nxt;
            fault_r <= fault_nxt;
        end
    end

    // Next state and timer: timed states load on entry and exit when the timer reads 0.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = (timer == '0) ? '0 : timer - 16'd1;
        timeout_fault = 1'b0;
        case (state)
            WAIT_POR: if (bus.por_complete) state_nxt = ACTIVE;
            ACTIVE: begin
                if (!supplies_ok) state_nxt = EMERG;
                else if (bus.pdn_req) begin
                    state_nxt = QUIESCE;
                    timer_nxt = QTO_LD;
                end
            end
            QUIESCE: begin
                if (!supplies_ok) state_nxt = EMERG;
                else if (!bus.pdn_req) state_nxt = ACTIVE;
                else if (bus.quiesce_ack) begin
                    state_nxt = ISO;
                    timer_nxt = ISO_LD;
                end
`ifdef SERDESPHY_PDN_TIMEOUT_EN
                else if (timer == '0) begin
                    state_nxt     = ISO;
                    timer_nxt     = ISO_LD;
                    timeout_fault = 1'b1;
                end
`endif
            end
            ISO: begin
                if (!supplies_ok) state_nxt = EMERG;
                else if (timer == '0) begin
                    state_nxt = ARST;
                    timer_nxt = RST_LD;
                end
            end
            ARST: begin
                if (!supplies_ok) state_nxt = EMERG;
                else if (timer == '0) begin
                    state_nxt = DRST;
                    timer_nxt = RST_LD;
                end
            end
            DRST: begin
                if (!supplies_ok) state_nxt = EMERG;
                else if (timer == '0) state_nxt = OFF;
            end
            OFF: begin
                if (!bus.por_complete) state_nxt = WAIT_POR;
                else if (!bus.pdn_req && supplies_ok) begin
                    state_nxt = WAKE_D;
                    timer_nxt = RST_LD;
                end
            end
            WAKE_D: begin
                if (!supplies_ok) state_nxt = EMERG;
                else if (timer == '0) begin
                    state_nxt = WAKE_A;
                    timer_nxt = ISO_LD;
                end
            end
            WAKE_A: begin
                if (!supplies_ok) state_nxt = EMERG;
                else if (timer == '0) state_nxt = WAKE_ISO;
            end
            WAKE_ISO: state_nxt = supplies_ok ? ACTIVE : EMERG;
            EMERG:    state_nxt = OFF;
            default:  state_nxt = EMERG;
        endcase
    end

    // Output values decoded from the state being entered, so they register on entry.
    always_comb begin
        q_nxt    = 1'b0;
        iso_nxt  = 1'b1;
        ar_nxt   = 1'b1;
        dr_nxt   = 1'b1;
        act_nxt  = 1'b0;
        done_nxt = 1'b0;
        case (state_nxt)
            QUIESCE: begin
                q_nxt = 1'b1; act_nxt = 1'b1;
            end
            ISO: begin
                q_nxt = 1'b1; act_nxt = 1'b1; iso_nxt = 1'b0;
            end
            ARST: begin
                q_nxt = 1'b1; act_nxt = 1'b1; iso_nxt = 1'b0; ar_nxt = 1'b0;
            end
            DRST: begin
                q_nxt = 1'b1; act_nxt = 1'b1; iso_nxt = 1'b0; ar_nxt = 1'b0; dr_nxt = 1'b0;
            end
            // quiesce_req keeps whatever the entry path left: 1 after DRST, 0 after EMERG.
            OFF: begin
                q_nxt = q_r; done_nxt = 1'b1; iso_nxt = 1'b0; ar_nxt = 1'b0; dr_nxt = 1'b0;
            end
            WAKE_D: begin
                act_nxt = 1'b1; iso_nxt = 1'b0; ar_nxt = 1'b0;
            end
            WAKE_A: begin
                act_nxt = 1'b1; iso_nxt = 1'b0;
            end
            WAKE_ISO: act_nxt = 1'b1;
            EMERG: begin
                act_nxt = 1'b1; iso_nxt = 1'b0; ar_nxt = 1'b0; dr_nxt = 1'b0;
            end
            default: ;
        endcase
        if ((state_nxt == EMERG) || timeout_fault) fault_nxt = 1'b1;
        else if (bus.fault_clr)                    fault_nxt = 1'b0;
        else                                       fault_nxt = fault_r;
    end

    assign bus.quiesce_req     = q_r;
    assign bus.analog_iso_n    = iso_r;
    assign bus.analog_reset_n  = ar_r;
    assign bus.digital_reset_n = dr_r;
    assign bus.pdn_active      = act_r;
    assign bus.pdn_done        = done_r;
    assign bus.pdn_fault       = fault_r;

endmodule

// File: tb/tb_serdesphy_pdn_seq.sv
// Directed bench for serdesphy_pdn_seq. Output vector order:
// {quiesce_req, analog_iso_n, analog_reset_n, digital_reset_n, pdn_active, pdn_done, pdn_fault}
module tb_serdesphy_pdn_seq;
    logic clk;
    logic rst_n_in;
    int   checks;
    int   errors;
    int   cyc;

    serdesphy_pdn_seq_if bus();

    serdesphy_pdn_seq #(
        .ISO_TIME(15),
        .RST_TIME(10),
        .QUIESCE_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst_n_in(rst_n_in),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {bus.quiesce_req, bus.analog_iso_n, bus.analog_reset_n,
                bus.digital_reset_n, bus.pdn_active, bus.pdn_done, bus.pdn_fault};
    endfunction

    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = outs();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n_in = 1'b1;
        bus.dvdd_ok = 1'b1;
        bus.avdd_ok = 1'b1;
        bus.por_complete = 1'b0;
        bus.pdn_req = 1'b0;
        bus.quiesce_ack = 1'b0;
        bus.fault_clr = 1'b0;

        // Reset, before any clock edge.
        #2 rst_n_in = 1'b0;
        #1 chk("reset_values", 7'b0111000);
        tick(); tick();
        rst_n_in = 1'b1;

        // WAIT_POR ignores pdn_req.
        bus.pdn_req = 1'b1;
        tick(); tick(); tick();
        chk("wait_por_hold", 7'b0111000);
        bus.pdn_req = 1'b0;
        bus.por_complete = 1'b1;
        tick();
        chk("active_idle", 7'b0111000);

        // Normal shutdown.
        cyc = 0;
        bus.pdn_req = 1'b1;
        wait_to(1);  chk("sd_quiesce_c1", 7'b1111100);
        wait_to(5);  chk("sd_quiesce_c5", 7'b1111100);
        bus.quiesce_ack = 1'b1;
        wait_to(6);  chk("sd_iso_c6", 7'b1011100);
        bus.quiesce_ack = 1'b0;
        wait_to(8);  bus.pdn_req = 1'b0;
        wait_to(9);  chk("sd_iso_ignore_req", 7'b1011100);
        bus.pdn_req = 1'b1;
        wait_to(21); chk("sd_iso_c21", 7'b1011100);
        wait_to(22); chk("sd_arst_c22", 7'b1001100);
        wait_to(32); chk("sd_arst_c32", 7'b1001100);
        wait_to(33); chk("sd_drst_c33", 7'b1000100);
        wait_to(43); chk("sd_drst_c43", 7'b1000100);
        wait_to(44); chk("sd_off_c44", 7'b1000010);

        // Wake.
        cyc = 0;
        bus.pdn_req = 1'b0;
        wait_to(1);  chk("wk_d_c1", 7'b0001100);
        wait_to(11); chk("wk_d_c11", 7'b0001100);
        wait_to(12); chk("wk_a_c12", 7'b0011100);
        wait_to(27); chk("wk_a_c27", 7'b0011100);
        wait_to(28); chk("wk_iso_c28", 7'b0111100);
        wait_to(29); chk("wk_active_c29", 7'b0111000);

        // Emergency during ARST, wake blocked while supply is down.
        cyc = 0;
        bus.pdn_req = 1'b1;
        wait_to(1);  bus.quiesce_ack = 1'b1;
        wait_to(2);  bus.quiesce_ack = 1'b0;
        chk("em_iso_c2", 7'b1011100);
        wait_to(18); chk("em_arst_c18", 7'b1001100);
        wait_to(20); bus.avdd_ok = 1'b0;
        wait_to(21); chk("em_emerg", 7'b0000101);
        wait_to(22); chk("em_off", 7'b0000011);
        bus.pdn_req = 1'b0;
        wait_to(25); chk("em_wake_blocked", 7'b0000011);
        bus.avdd_ok = 1'b1;
        wait_to(26); chk("em_wake_keeps_fault", 7'b0001101);
        bus.fault_clr = 1'b1;
        wait_to(27); bus.fault_clr = 1'b0;
        chk("em_fault_clr", 7'b0001100);
        wait_to(54); chk("em_back_active", 7'b0111000);

        // Supply loss with pdn_req and fault_clr in ACTIVE: EMERG and fault set win.
        cyc = 0;
        bus.avdd_ok = 1'b0;
        bus.pdn_req = 1'b1;
        bus.fault_clr = 1'b1;
        wait_to(1);  bus.fault_clr = 1'b0;
        chk("sim_emerg_wins", 7'b0000101);
        wait_to(2);  chk("sim_off", 7'b0000011);
        bus.pdn_req = 1'b0;
        bus.fault_clr = 1'b1;
        wait_to(3);  bus.fault_clr = 1'b0;
        chk("sim_fault_clr", 7'b0000010);
        bus.por_complete = 1'b0;
        wait_to(4);  chk("sim_off_to_por", 7'b0111000);
        bus.avdd_ok = 1'b1;
        bus.por_complete = 1'b1;
        wait_to(5);

        // Abort before quiesce_ack.
        cyc = 0;
        bus.pdn_req = 1'b1;
        wait_to(1);  chk("ab_quiesce_c1", 7'b1111100);
        wait_to(3);  chk("ab_quiesce_c3", 7'b1111100);
        bus.pdn_req = 1'b0;
        wait_to(4);  chk("ab_active_c4", 7'b0111000);
        wait_to(6);  chk("ab_active_c6", 7'b0111000);

        // Quiesce timeout (or indefinite wait).
        cyc = 0;
        bus.pdn_req = 1'b1;
`ifdef SERDESPHY_PDN_TIMEOUT_EN
        wait_to(65); chk("to_wait_c65", 7'b1111100);
        wait_to(66); chk("to_fault_c66", 7'b1011101);
`else
        wait_to(1000); chk("to_wait_c1000", 7'b1111100);
`endif

        // Async reset in the middle of a shutdown.
        #2 rst_n_in = 1'b0;
        #1 chk("ar_reset_pre", 7'b0111000);
        tick();
        bus.pdn_req = 1'b0;
        rst_n_in = 1'b1;
        tick();
        cyc = 0;
        bus.pdn_req = 1'b1;
        wait_to(5);  bus.quiesce_ack = 1'b1;
        wait_to(6);  bus.quiesce_ack = 1'b0;
        wait_to(25); chk("ar_arst_c25", 7'b1001100);
        #2 rst_n_in = 1'b0;
        #1 chk("ar_async_values", 7'b0111000);
        bus.por_complete = 1'b0;
        tick();
        rst_n_in = 1'b1;
        tick(); tick(); tick();
        chk("ar_wait_por", 7'b0111000);
        bus.por_complete = 1'b1;
        tick();
        chk("ar_active", 7'b0111000);
        tick();
        chk("ar_quiesce", 7'b1111100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
